// File: rtl/irda_sir_link_ctrl.sv
// irda_sir_link_ctrl: half-duplex SIR link sequencer with 16x tick generator, turnaround
// timing and RX byte assembly from decoded SIR bits.
module irda_sir_link_ctrl #(
    parameter int DIV_W  = 16,
    parameter int TURN_W = 8
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic              sir_en,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [TURN_W-1:0] turnaround,
    input  logic              tx_req,
    input  logic              tx_done,
    output logic              tx_grant,
    output logic              tx_select,
    output logic              fast_enable,
    output logic              fast_mode,
    input  logic              sir_dec_i,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    output logic              busy
);
    typedef enum logic [1:0] {LISTEN, TURN_TX, TX, TURN_RX} link_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_STOP} rx_t;

    link_t             link_q, link_d;
    rx_t               rx_q, rx_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              fast_enable_q, fast_enable_d;
    logic              fast_mode_q, fast_mode_d;
    logic [3:0]        phase_q, phase_d;
    logic              bit_strobe_q, bit_strobe_d;
    logic [3:0]        turn_sub_q, turn_sub_d;
    logic [TURN_W-1:0] turn_per_q, turn_per_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              load;

    assign tx_grant     = link_q == TX;
    assign tx_select    = link_q != LISTEN;
    assign fast_enable  = fast_enable_q;
    assign fast_mode    = fast_mode_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = frame_err_q;
    assign rx_overrun   = overrun_q;
    assign busy         = !(link_q == LISTEN && rx_q == R_IDLE);

    // Phase mirror follows the decoder's 16-tick counter; the strobe marks its bit centre.
    always_comb begin
        div_cnt_d     = (!sir_en || div_cnt_q == '0) ? divisor : div_cnt_q - 1'b1;
        fast_enable_d = sir_en && div_cnt_d == '0;
        fast_mode_d   = ~sir_en;
        phase_d       = fast_mode_q ? 4'h0 : phase_q + {3'b000, fast_enable_q & ~tx_select};
        bit_strobe_d  = sir_en & fast_enable_q & ~tx_select & ~fast_mode_q & (phase_q == 4'hf);
    end

    always_comb begin
        link_d     = link_q;
        turn_sub_d = turn_sub_q;
        turn_per_d = turn_per_q;
        if (!sir_en) begin
            link_d     = LISTEN;
            turn_sub_d = '0;
            turn_per_d = '0;
        end else begin
            case (link_q)
                LISTEN: if (tx_req && rx_q == R_IDLE) begin
                    link_d     = TURN_TX;
                    turn_sub_d = '0;
                    turn_per_d = '0;
                end
                TX: if (tx_done) begin
                    link_d     = TURN_RX;
                    turn_sub_d = '0;
                    turn_per_d = '0;
                end
                TURN_TX, TURN_RX: if (turn_per_q == turnaround) begin
                    link_d = (link_q == TURN_TX) ? TX : LISTEN;
                end else if (fast_enable_q) begin
                    turn_sub_d = turn_sub_q + 1'b1;
                    turn_per_d = (turn_sub_q == 4'hf) ? turn_per_q + 1'b1 : turn_per_q;
                end
            endcase
        end
    end

    // A start bit arriving together with tx_req is dropped: the link leaves LISTEN.
    always_comb begin
        rx_d        = rx_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        load        = 1'b0;
        frame_err_d = 1'b0;
        if (!sir_en || link_q != LISTEN) begin
            rx_d = R_IDLE;
        end else if (bit_strobe_q) begin
            case (rx_q)
                R_IDLE: if (!sir_dec_i && !tx_req) begin
                    rx_d      = R_DATA;
                    bit_cnt_d = 3'd0;
                end
                R_DATA: begin
                    shift_d   = {sir_dec_i, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    rx_d      = (bit_cnt_q == 3'd7) ? R_STOP : R_DATA;
                end
                R_STOP: begin
                    rx_d        = R_IDLE;
                    load        = sir_dec_i;
                    frame_err_d = ~sir_dec_i;
                end
                default: rx_d = R_IDLE;
            endcase
        end
    end

    always_comb begin
        overrun_d  = load & rx_valid_q & ~rx_ready;
        rx_data_d  = (load && !overrun_d) ? shift_q : rx_data_q;
        rx_valid_d = load | (rx_valid_q & ~rx_ready);
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            link_q        <= LISTEN;
            rx_q          <= R_IDLE;
            div_cnt_q     <= '0;
            fast_enable_q <= 1'b0;
            fast_mode_q   <= 1'b1;
            phase_q       <= 4'h0;
            bit_strobe_q  <= 1'b0;
            turn_sub_q    <= 4'h0;
            turn_per_q    <= '0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            link_q        <= link_d;
            rx_q          <= rx_d;
            div_cnt_q     <= div_cnt_d;
            fast_enable_q <= fast_enable_d;
            fast_mode_q   <= fast_mode_d;
            phase_q       <= phase_d;
            bit_strobe_q  <= bit_strobe_d;
            turn_sub_q    <= turn_sub_d;
            turn_per_q    <= turn_per_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            overrun_q     <= overrun_d;
        end
    end
endmodule

// File: tb/tb_irda_sir_link_ctrl.sv
// tb_irda_sir_link_ctrl: the bench plays the SIR decoder (one bit per 16 ticks) and the
// TX/FIFO sides, checking ticks, received bytes, error pulses and turnaround timing.
module tb_irda_sir_link_ctrl;
    logic        clk = 1'b0;
    logic        wb_rst_i, sir_en, tx_req, tx_done, sir_dec_i, rx_ready;
    logic [15:0] divisor;
    logic [7:0]  turnaround;
    logic        tx_grant, tx_select, fast_enable, fast_mode;
    logic        rx_valid, rx_frame_err, rx_overrun, busy;
    logic [7:0]  rx_data;

    int tests = 0, fails = 0;
    int tick_cnt = 0, npop = 0, ferr_cnt = 0, ovr_cnt = 0;
    logic       bitq[$];
    logic [7:0] acc_q[$];

    typedef struct { int div; int turn; int ticks; } turn_vec_t;

    irda_sir_link_ctrl #(.DIV_W(16), .TURN_W(8)) dut (
        .clk(clk), .wb_rst_i(wb_rst_i), .sir_en(sir_en), .divisor(divisor),
        .turnaround(turnaround), .tx_req(tx_req), .tx_done(tx_done),
        .tx_grant(tx_grant), .tx_select(tx_select), .fast_enable(fast_enable),
        .fast_mode(fast_mode), .sir_dec_i(sir_dec_i), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_frame_err(rx_frame_err),
        .rx_overrun(rx_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One clock: acceptance is judged on the values just before the edge, then the
    // decoder model advances and presents a new bit every 16th tick.
    task automatic step();
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        @(posedge clk);
        #1;
        if (fast_mode) tick_cnt = 0;
        else if (fast_enable && !tx_select) begin
            tick_cnt++;
            if (tick_cnt % 16 == 0) begin
                if (bitq.size() != 0) begin
                    sir_dec_i = bitq.pop_front();
                    npop++;
                end else sir_dec_i = 1'b1;
            end
        end
        ferr_cnt += int'(rx_frame_err);
        ovr_cnt  += int'(rx_overrun);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic s);
        bitq.push_back(1'b0);
        for (int i = 0; i < 8; i++) bitq.push_back(d[i]);
        bitq.push_back(s);
    endtask

    task automatic clear_mon();
        acc_q.delete();
        ferr_cnt = 0;
        ovr_cnt  = 0;
        npop     = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bitq.size() != 0 && n < 30000) begin
            step();
            n++;
        end
        check1("queue_drain", n < 30000, 1'b1);
        repeat (32 * (int'(divisor) + 1) + 8) step();
    endtask

    // Counts ticks seen in turnaround cycles, excluding the final cycle that only
    // performs the exit; cycles is the index of the first cycle after the turnaround.
    task automatic measure(input logic to_grant, output int ticks, output int cycles);
        logic pend;
        ticks  = 0;
        pend   = fast_enable;
        step();
        cycles = 1;
        while ((to_grant ? !tx_grant : tx_select) && cycles < 20000) begin
            ticks += int'(pend);
            pend   = fast_enable;
            step();
            cycles++;
        end
        check1("turn_bounded", cycles < 20000, 1'b1);
    endtask

    task automatic full_tx(output int t1, output int c1, output int t2, output int c2);
        measure(1'b1, t1, c1);
        tx_req  = 1'b0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check1("grant_drop", tx_grant, 1'b0);
        check1("select_hold_rx", tx_select, 1'b1);
        measure(1'b0, t2, c2);
    endtask

    initial begin
        turn_vec_t  tv[5];
        logic [7:0] expq[$];
        int t1, c1, t2, c2, lo, hi, d, n, ef;
        logic early;
        tv[0] = '{3, 2, 32};
        tv[1] = '{0, 0, 0};
        tv[2] = '{1, 1, 16};
        tv[3] = '{2, 3, 48};
        tv[4] = '{0, 1, 16};

        wb_rst_i = 1'b1; sir_en = 1'b0; divisor = 16'd3; turnaround = 8'd2;
        tx_req = 1'b0; tx_done = 1'b0; sir_dec_i = 1'b1; rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", int'({tx_grant, tx_select, fast_enable, fast_mode,
                                  rx_valid, rx_frame_err, rx_overrun, busy}), 'h10);
        check("reset_data", int'(rx_data), 0);
        wb_rst_i = 1'b0;
        step();

        // Tick generator: first pulse after divisor cycles, then every divisor+1.
        for (int r = 0; r < 5; r++) begin
            d = (r == 0) ? 3 : int'($urandom_range(0, 4));
            sir_en  = 1'b0;
            divisor = 16'(d);
            step();
            step();
            check1("fe_off", fast_enable, 1'b0);
            sir_en = 1'b1;
            for (int k = 1; k <= 4 * (d + 1) + 3; k++) begin
                step();
                if (k == 1) check1("fast_mode_fall", fast_mode, 1'b0);
                check1("fe_period", fast_enable, (d == 0) || (k >= d && (k - d) % (d + 1) == 0));
            end
            sir_en = 1'b0;
            step();
            check1("fe_stop", fast_enable, 1'b0);
            check1("fast_mode_rise", fast_mode, 1'b1);
        end

        sir_en = 1'b1; divisor = 16'd0; turnaround = 8'd1;
        repeat (4) step();

        clear_mon();
        send_frame(8'hA5, 1'b1);
        wait_idle();
        check("a5_count", acc_q.size(), 1);
        if (acc_q.size() == 1) check("a5_data", int'(acc_q[0]), 'hA5);
        check("a5_ferr", ferr_cnt, 0);
        check("a5_ovr", ovr_cnt, 0);

        clear_mon();
        send_frame(8'hA5, 1'b0);
        bitq.push_back(1'b1);
        send_frame(8'h3C, 1'b1);
        wait_idle();
        check("ferr_pulses", ferr_cnt, 1);
        check("ferr_count", acc_q.size(), 1);
        if (acc_q.size() == 1) check("ferr_next", int'(acc_q[0]), 'h3C);

        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_idle();
        check1("ovr_valid", rx_valid, 1'b1);
        check("ovr_data", int'(rx_data), 'h11);
        check("ovr_pulses", ovr_cnt, 1);
        rx_ready = 1'b1;
        step();
        step();
        check("ovr_drain", acc_q.size(), 1);
        if (acc_q.size() == 1) check("ovr_drain_data", int'(acc_q[0]), 'h11);
        check1("ovr_valid_clr", rx_valid, 1'b0);

        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        step();
        check1("stray_done", tx_select | busy, 1'b0);

        foreach (tv[i]) begin
            divisor    = 16'(tv[i].div);
            turnaround = 8'(tv[i].turn);
            step();
            tx_req = 1'b1;
            step();
            check1("turn_tx_sel", tx_select, 1'b1);
            check1("turn_tx_grant", tx_grant, 1'b0);
            full_tx(t1, c1, t2, c2);
            lo = tv[i].turn == 0 ? 1 : 16 * tv[i].turn * (tv[i].div + 1) - tv[i].div + 1;
            hi = tv[i].turn == 0 ? 1 : 16 * tv[i].turn * (tv[i].div + 1) + 1;
            check("turn_tx_ticks", t1, tv[i].ticks);
            check1("turn_tx_cycles", c1 >= lo && c1 <= hi, 1'b1);
            check("turn_rx_ticks", t2, tv[i].ticks);
            check1("turn_rx_cycles", c2 >= lo && c2 <= hi, 1'b1);
            check1("turn_idle", busy, 1'b0);
        end

        // tx_req during data bit 4 waits for the frame to be delivered.
        divisor = 16'd0; turnaround = 8'd1;
        step();
        clear_mon();
        send_frame(8'h5A, 1'b1);
        n = 0;
        while (npop < 6 && n < 5000) begin step(); n++; end
        tx_req = 1'b1;
        early  = 1'b0;
        n = 0;
        while (!rx_valid && n < 5000) begin
            early |= tx_select;
            step();
            n++;
        end
        check1("defer_no_early", early, 1'b0);
        check("defer_data", int'(rx_data), 'h5A);
        step();
        check1("defer_then_tx", tx_select, 1'b1);
        full_tx(t1, c1, t2, c2);
        check("defer_count", acc_q.size(), 1);
        check("defer_ferr", ferr_cnt, 0);

        // tx_req on the start-bit strobe: TX wins, the frame is never started.
        clear_mon();
        send_frame(8'hC3, 1'b1);
        n = 0;
        while (npop < 1 && n < 5000) begin step(); n++; end
        step();
        tx_req = 1'b1;
        step();
        check1("start_tx_wins", tx_select & busy, 1'b1);
        bitq.delete();
        sir_dec_i = 1'b1;
        full_tx(t1, c1, t2, c2);
        repeat (40) step();
        check("start_no_byte", acc_q.size(), 0);
        check("start_no_ferr", ferr_cnt, 0);
        check1("start_idle", busy, 1'b0);

        // sir_en dropped while granted: link released, pending byte kept.
        clear_mon();
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1);
        wait_idle();
        tx_req = 1'b1;
        step();
        measure(1'b1, t1, c1);
        check1("sir_off_granted", tx_grant, 1'b1);
        sir_en = 1'b0;
        step();
        check("sir_off_ctrl", int'({tx_grant, tx_select, fast_mode, rx_valid}), 'h3);
        check("sir_off_data", int'(rx_data), 'h77);
        tx_req = 1'b0; sir_en = 1'b1;
        repeat (3) step();

        // Asynchronous reset in the middle of a cycle.
        tx_req = 1'b1;
        step();
        #2 wb_rst_i = 1'b1;
        #1;
        check("async_reset_ctrl", int'({tx_grant, tx_select, fast_enable, fast_mode,
                                        rx_valid, rx_frame_err, rx_overrun, busy}), 'h10);
        check("async_reset_data", int'(rx_data), 0);
        tx_req = 1'b0;
        step();
        wb_rst_i = 1'b0;
        rx_ready = 1'b1;
        repeat (3) step();

        // Random frames against a byte-level model: good stop bits deliver, bad ones flag.
        for (int r = 0; r < 3; r++) begin
            divisor = 16'($urandom_range(0, 2));
            clear_mon();
            expq.delete();
            ef = 0;
            for (int f = 0; f < 6; f++) begin
                logic [7:0] b;
                logic s;
                b = 8'($urandom);
                s = $urandom_range(0, 3) != 0;
                send_frame(b, s);
                if (s) expq.push_back(b);
                else ef++;
                repeat ($urandom_range(0, 2)) bitq.push_back(1'b1);
            end
            wait_idle();
            check("rand_count", acc_q.size(), expq.size());
            for (int i = 0; i < expq.size() && i < acc_q.size(); i++)
                check("rand_data", int'(acc_q[i]), int'(expq[i]));
            check("rand_ferr", ferr_cnt, ef);
            check("rand_ovr", ovr_cnt, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
